hilo_div_ctrl: RTL and testbench
================================

HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 The block SHALL have clock `clock` and reset `reset`: asynchronous, active-high.
REQ-002 The ports SHALL be, one per line, as follows (clock and reset first):
- clock  in  1  system clock, rising edge.
- reset  in  1  async active-high reset.
- req  in  1  divide request from EX stage, one-cycle pulse.
- dividend_in  in  32  rs operand, valid with req.
- divisor_in  in  32  rt operand, valid with req.
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  32  move-to data.
- div_start  out  1  start to sequential divider; operands latched by divider on falling edge of div_start.
- div_dividend  out  32  held operand to divider.
- div_divisor  out  32  held operand to divider.
- div_busy  in  1  divider busy.
- div_q  in  32  divider quotient.
- div_r  in  32  divider remainder.
- hi  out  32  HI register (remainder).
- lo  out  32  LO register (quotient).
- stall  out  1  pipeline hold.
- done  out  1  one-cycle pulse, HI/LO updated.

Function
REQ-003 The block SHALL implement FSM states IDLE, START, LAUNCH, WAIT, WRITE.
REQ-004 IDLE + req SHALL latch dividend_in/divisor_in into operand registers and go to START.
REQ-005 START SHALL drive div_start=1 for exactly one cycle, then go to LAUNCH.
REQ-006 LAUNCH SHALL drive div_start=0 with operands held, set seen_busy=0, then go to WAIT.
REQ-007 WAIT SHALL set seen_busy on div_busy=1 and go to WRITE on the first cycle with div_busy=0 and seen_busy=1.
REQ-008 WRITE SHALL load lo<=div_q and hi<=div_r, assert done for one cycle, then return to IDLE.
REQ-009 div_start SHALL be 0 in all states except START.
REQ-010 div_dividend/div_divisor SHALL be stable from START through WRITE.
REQ-011 stall SHALL be combinationally 1 when (IDLE and req) or state != IDLE, i.e. from the request cycle through WRITE inclusive; stall SHALL be 0 in IDLE without req.
REQ-012 Latency SHALL be req at cycle 0, START at 1, LAUNCH at 2, divider busy for 32 cycles, WRITE/done at 35 for a 32-cycle divider; HI/LO SHALL be visible at 36.
REQ-013 mthi/mtlo SHALL write in IDLE only, taking effect on the next edge; both set SHALL write both registers.
REQ-014 mthi/mtlo SHALL be ignored in any non-IDLE state.
REQ-015 req with mthi/mtlo in the same IDLE cycle SHALL have the move write and the divide start; the divide result later overwrites.
REQ-016 req while not IDLE SHALL be ignored (never occurs because stall holds upstream).
REQ-017 Signed-ness SHALL be owned by the divider; results are stored bit-exact, with no width change.

Reset
REQ-018 Reset SHALL set state=IDLE, hi=0, lo=0, operand regs=0, seen_busy=0, div_start=0, stall=0, done=0.
REQ-019 Reset mid-divide SHALL abort: no HI/LO write and no done; the divider is reset by the same net.

Configuration
REQ-020 With DIV_ZERO_BYPASS_EN defined, IDLE + req with divisor_in==0 SHALL go straight to WRITE next cycle, loading lo=32'hFFFFFFFF and hi=dividend_in, with no div_start; done and stall follow normal WRITE rules, for a 2-cycle latency.
REQ-021 Without DIV_ZERO_BYPASS_EN, divide-by-zero SHALL go through the divider like any operand and the result is whatever the divider returns.

Structure
REQ-022 A shared package SHALL hold the FSM state encoding (3-bit enum IDLE..WRITE), the constant WORD_W=32 and the bypass quotient constant DIV0_Q=32'hFFFFFFFF.
REQ-023 One sub-module, hilo_regs, SHALL hold HI/LO with move-to and divide-write ports, divide write having priority.
REQ-024 The divider SHALL stay outside this block, connected at the parent level.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- 100/7 with a 32-cycle divider model: req at cycle 0 -> div_start high only at cycle 1; done at 35; lo=14, hi=2; stall high cycles 0..35.
- -7/2 (0xFFFFFFF9 / 2): lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- mthi 0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle; mtlo asserted during WAIT -> lo unchanged.
- reset asserted at cycle 10 of a divide -> state IDLE, hi/lo=0, no done pulse; a subsequent 9/3 gives lo=3, hi=0.
- DIV_ZERO_BYPASS_EN, 5/0 -> done at cycle 1, lo=0xFFFFFFFF, hi=5, div_start never high; without the macro, div_start pulses.
- req + mtlo 0x1234 in the same cycle, 8/4 -> lo=0x1234 at cycle 1, then lo=2 after done.

Source files
------------

// File: rtl/hilo_div_ctrl_pkg.sv
// ============================================================================
// hilo_div_ctrl_pkg
// Shared FSM state encoding and word-level constants for the HI/LO divide
// controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hilo_div_ctrl_pkg;

  localparam int WORD_W = 32;

  // Quotient written when a divide-by-zero skips the divider.
  localparam logic [WORD_W-1:0] DIV0_Q = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    WRITE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/hilo_div_ctrl_regs.sv
// ============================================================================
// hilo_regs
// HI/LO architectural registers. The move-to and divide-result write ports
// are both provided; the divide-result write has priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hilo_regs
  import hilo_div_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              mv_hi_we_i,
  input  logic              mv_lo_we_i,
  input  logic [WORD_W-1:0] mv_data_i,
  input  logic              div_we_i,
  input  logic [WORD_W-1:0] div_hi_i,
  input  logic [WORD_W-1:0] div_lo_i,
  output logic [WORD_W-1:0] hi_o,
  output logic [WORD_W-1:0] lo_o
);

  logic [WORD_W-1:0] hi_q, hi_d;
  logic [WORD_W-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_we_i) begin
      hi_d = div_hi_i;
      lo_d = div_lo_i;
    end else begin
      if (mv_hi_we_i) hi_d = mv_data_i;
      if (mv_lo_we_i) lo_d = mv_data_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

`default_nettype wire

// File: rtl/hilo_div_ctrl.sv
// ============================================================================
// hilo_div_ctrl
// Sequences an external sequential divider and owns HI/LO. Optional macro
// DIV_ZERO_BYPASS_EN short-circuits divide-by-zero straight to WRITE.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [WORD_W-1:0] dividend_in,
  input  logic [WORD_W-1:0] divisor_in,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [WORD_W-1:0] wdata,
  output logic              div_start,
  output logic [WORD_W-1:0] div_dividend,
  output logic [WORD_W-1:0] div_divisor,
  input  logic              div_busy,
  input  logic [WORD_W-1:0] div_q,
  input  logic [WORD_W-1:0] div_r,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo,
  output logic              stall,
  output logic              done
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] dividend_q, dividend_d;
  logic [WORD_W-1:0] divisor_q, divisor_d;
  logic              seen_busy_q, seen_busy_d;

  logic              zero_req;
  logic              bypass_wr;
  logic              div_we;
  logic [WORD_W-1:0] wr_hi;
  logic [WORD_W-1:0] wr_lo;

`ifdef DIV_ZERO_BYPASS_EN
  // A zero divisor never reaches the divider, so a zero held operand in
  // WRITE always marks the bypass path.
  assign zero_req  = (divisor_in == '0);
  assign bypass_wr = (divisor_q == '0);
`else
  assign zero_req  = 1'b0;
  assign bypass_wr = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      seen_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      seen_busy_q <= seen_busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    seen_busy_d = seen_busy_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          dividend_d = dividend_in;
          divisor_d  = divisor_in;
          state_d    = zero_req ? WRITE : START;
        end
      end
      START:  state_d = LAUNCH;
      LAUNCH: begin
        seen_busy_d = 1'b0;
        state_d     = WAIT;
      end
      WAIT: begin
        // Busy must be observed first so a slow-to-rise busy is not
        // mistaken for completion.
        if (div_busy) seen_busy_d = 1'b1;
        if (!div_busy && seen_busy_q) state_d = WRITE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign div_start    = (state_q == START);
  assign done         = (state_q == WRITE);
  assign stall        = (state_q != IDLE) || req;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

  assign div_we = (state_q == WRITE);
  assign wr_lo  = bypass_wr ? DIV0_Q : div_q;
  assign wr_hi  = bypass_wr ? dividend_q : div_r;

  hilo_regs u_regs (
    .clock      (clock),
    .reset      (reset),
    .mv_hi_we_i (mthi && (state_q == IDLE)),
    .mv_lo_we_i (mtlo && (state_q == IDLE)),
    .mv_data_i  (wdata),
    .div_we_i   (div_we),
    .div_hi_i   (wr_hi),
    .div_lo_i   (wr_lo),
    .hi_o       (hi),
    .lo_o       (lo)
  );

endmodule

`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
// ============================================================================
// tb_hilo_div_ctrl
// Directed bench for hilo_div_ctrl with a 32-cycle signed divider model.
// Expectations follow DIV_ZERO_BYPASS_EN when it is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hilo_div_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] dividend_in;
  logic [31:0] divisor_in;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_busy;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;
  logic        done;

  int vectors = 0;
  int errors  = 0;
  int done_cnt = 0;

  hilo_div_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .dividend_in  (dividend_in),
    .divisor_in   (divisor_in),
    .mthi         (mthi),
    .mtlo         (mtlo),
    .wdata        (wdata),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_busy     (div_busy),
    .div_q        (div_q),
    .div_r        (div_r),
    .hi           (hi),
    .lo           (lo),
    .stall        (stall),
    .done         (done)
  );

  always #5 clock = ~clock;

  // Divider: busy for 32 cycles after seeing start, signed results.
  logic [31:0] m_a, m_b;
  int          m_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      div_busy <= 1'b0;
      div_q    <= '0;
      div_r    <= '0;
      m_a      <= '0;
      m_b      <= '0;
      m_cnt    <= 0;
    end else if (div_start) begin
      div_busy <= 1'b1;
      m_cnt    <= 31;
      m_a      <= div_dividend;
      m_b      <= div_divisor;
    end else if (div_busy) begin
      if (m_cnt == 0) begin
        div_busy <= 1'b0;
        if (m_b == 32'd0) begin
          div_q <= 32'hFFFF_FFFF;
          div_r <= m_a;
        end else begin
          div_q <= 32'($signed(m_a) / $signed(m_b));
          div_r <= 32'($signed(m_a) % $signed(m_b));
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(posedge clock) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Called at a cycle start; req is the cycle-0 pulse.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int done_at,
                         input logic start_exp, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input logic chk_lo1,
                         input logic [31:0] lo1);
    req = 1'b1; dividend_in = a; divisor_in = b;
    #1;
    chk("stall_c0", 32'(stall), 32'd1);
    chk("start_c0", 32'(div_start), 32'd0);
    for (int c = 1; c <= done_at; c++) begin
      cyc();
      req = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      dividend_in = 32'hA5A5_A5A5; divisor_in = 32'h5A5A_5A5A;
      #1;
      chk("div_start", 32'(div_start), 32'(start_exp && (c == 1)));
      chk("done", 32'(done), 32'(c == done_at));
      chk("stall", 32'(stall), 32'd1);
      chk("dividend_held", div_dividend, a);
      chk("divisor_held", div_divisor, b);
      if (chk_lo1 && c == 1) chk("lo_c1", lo, lo1);
    end
    cyc();
    #1;
    chk("stall_after", 32'(stall), 32'd0);
    chk("done_after", 32'(done), 32'd0);
    chk("lo_result", lo, exp_lo);
    chk("hi_result", hi, exp_hi);
  endtask

  initial begin
    int saved;
    reset = 1'b1; req = 1'b0; dividend_in = '0; divisor_in = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    cyc(); cyc();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_start", 32'(div_start), 32'd0);
    chk("rst_dividend", div_dividend, 32'd0);
    reset = 1'b0;
    cyc();

    run_div(32'd100, 32'd7, 35, 1'b1, 32'd14, 32'd2, 1'b0, 32'd0);
    cyc();
    run_div(32'hFFFF_FFF9, 32'd2, 35, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32'd0);

    // Move-to in IDLE, then a move-to during WAIT that must be dropped.
    cyc();
    mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    #1;
    chk("mthi_nostall", 32'(stall), 32'd0);
    cyc();
    mthi = 1'b0;
    #1;
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_lo_keep", lo, 32'hFFFF_FFFD);
    req = 1'b1; dividend_in = 32'd50; divisor_in = 32'd5;
    for (int i = 0; i < 5; i++) begin
      cyc();
      req = 1'b0;
    end
    mtlo = 1'b1; wdata = 32'h0000_0055;
    cyc();
    mtlo = 1'b0;
    #1;
    chk("mtlo_wait_lo", lo, 32'hFFFF_FFFD);
    chk("mtlo_wait_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 60 && !done; i++) cyc();
    chk("wait_done_seen", 32'(done), 32'd1);
    cyc();
    chk("d50_lo", lo, 32'd10);
    chk("d50_hi", hi, 32'd0);

    // Reset in the middle of a divide aborts it.
    cyc();
    req = 1'b1; dividend_in = 32'd1000; divisor_in = 32'd10;
    for (int i = 0; i < 10; i++) begin
      cyc();
      req = 1'b0;
    end
    saved = done_cnt;
    reset = 1'b1;
    #1;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) cyc();
    chk("abort_no_done", 32'(done_cnt), 32'(saved));
    chk("abort_lo_keep", lo, 32'd0);
    chk("abort_hi_keep", hi, 32'd0);
    run_div(32'd9, 32'd3, 35, 1'b1, 32'd3, 32'd0, 1'b0, 32'd0);

    cyc();
`ifdef DIV_ZERO_BYPASS_EN
    run_div(32'd5, 32'd0, 1, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b0, 32'd0);
`else
    run_div(32'd5, 32'd0, 35, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b0, 32'd0);
`endif

    // Move-to and divide request in the same cycle.
    cyc();
    mtlo = 1'b1; wdata = 32'h0000_1234;
    run_div(32'd8, 32'd4, 35, 1'b1, 32'd2, 32'd0, 1'b1, 32'h0000_1234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
